tdm_demux4: RTL

Four-slot time-division demultiplexer: the receive-side counterpart of the 4:1 select path in the ADLD datapath blocks. It takes a serial stream of W-bit samples, one sample per slot and four slots per frame, marked by a frame-sync strobe on slot 0. It routes each sample to one of four channel registers and presents a complete frame on all four outputs at once. A small sync FSM hunts for frame alignment, tracks slot position and flags framing errors.

---
 rtl/tdm_demux4.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/tdm_demux4.sv
// Four-slot TDM demultiplexer: aligns on fsync, stages slots 0..2, publishes a full frame on slot 3.
// Optional even-parity checking is built when TDM_DEMUX_PARITY_EN is defined.
module tdm_demux4 #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] din,
    input  logic         din_valid,
    input  logic         fsync,
`ifdef TDM_DEMUX_PARITY_EN
    input  logic         din_par,
`endif
    output logic [W-1:0] y0,
    output logic [W-1:0] y1,
    output logic [W-1:0] y2,
    output logic [W-1:0] y3,
    output logic [1:0]   slot,
    output logic         frame_valid,
    output logic         locked,
    output logic         sync_err
`ifdef TDM_DEMUX_PARITY_EN
    ,
    output logic         par_err
`endif
);

    typedef enum logic {HUNT = 1'b0, LOCK = 1'b1} state_t;

    state_t       state_q, state_d;
    logic [W-1:0] st0_q, st1_q, st2_q;
    logic [W-1:0] st0_d, st1_d, st2_d;
    logic [W-1:0] y0_d, y1_d, y2_d, y3_d;
    logic [1:0]   slot_d;
    logic         fv_d, se_d;
    logic         frame_ok;

`ifdef TDM_DEMUX_PARITY_EN
    logic bad_q, bad_d, bad_beat, pe_d;
    // Parity only matters once aligned; beats seen while hunting are never checked.
    assign bad_beat = din_valid && (state_q == LOCK) && ((^din) ^ din_par);
    assign frame_ok = !(bad_q || bad_beat);
`else
    assign frame_ok = 1'b1;
`endif

    always_comb begin
        state_d = state_q;
        slot_d  = slot;
        st0_d   = st0_q;
        st1_d   = st1_q;
        st2_d   = st2_q;
        y0_d    = y0;
        y1_d    = y1;
        y2_d    = y2;
        y3_d    = y3;
        fv_d    = 1'b0;
        se_d    = 1'b0;
`ifdef TDM_DEMUX_PARITY_EN
        bad_d   = bad_q;
        pe_d    = bad_beat;
`endif
        if (din_valid) begin
            if (state_q == HUNT) begin
                if (fsync) begin
                    st0_d   = din;
                    slot_d  = 2'd1;
                    state_d = LOCK;
`ifdef TDM_DEMUX_PARITY_EN
                    bad_d   = 1'b0;
`endif
                end
            end else if (fsync) begin
                // Sync anywhere but slot 0 is an early sync: restart the frame on this beat.
                se_d   = (slot != 2'd0);
                st0_d  = din;
                slot_d = 2'd1;
`ifdef TDM_DEMUX_PARITY_EN
                bad_d  = bad_beat;
`endif
            end else if (slot == 2'd0) begin
                se_d    = 1'b1;
                slot_d  = 2'd0;
                state_d = HUNT;
`ifdef TDM_DEMUX_PARITY_EN
                bad_d   = 1'b0;
`endif
            end else if (slot == 2'd3) begin
                if (frame_ok) begin
                    y0_d = st0_q;
                    y1_d = st1_q;
                    y2_d = st2_q;
                    y3_d = din;
                    fv_d = 1'b1;
                end
                slot_d = 2'd0;
`ifdef TDM_DEMUX_PARITY_EN
                bad_d  = 1'b0;
`endif
            end else begin
                if (slot == 2'd1) st1_d = din;
                else              st2_d = din;
                slot_d = slot + 2'd1;
`ifdef TDM_DEMUX_PARITY_EN
                bad_d  = bad_q || bad_beat;
`endif
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= HUNT;
            slot        <= 2'd0;
            st0_q       <= '0;
            st1_q       <= '0;
            st2_q       <= '0;
            y0          <= '0;
            y1          <= '0;
            y2          <= '0;
            y3          <= '0;
            frame_valid <= 1'b0;
            sync_err    <= 1'b0;
`ifdef TDM_DEMUX_PARITY_EN
            bad_q       <= 1'b0;
            par_err     <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            slot        <= slot_d;
            st0_q       <= st0_d;
            st1_q       <= st1_d;
            st2_q       <= st2_d;
            y0          <= y0_d;
            y1          <= y1_d;
            y2          <= y2_d;
            y3          <= y3_d;
            frame_valid <= fv_d;
            sync_err    <= se_d;
`ifdef TDM_DEMUX_PARITY_EN
            bad_q       <= bad_d;
            par_err     <= pe_d;
`endif
        end
    end

    assign locked = (state_q == LOCK);

endmodule
